// File: rtl/mac_pkg.sv
// ============================================================================
// mac_pkg : opcode/state encodings and shared constants for mac and mac_seq
// Revision: 1.0
// ============================================================================
`default_nettype none

package mac_pkg;

   typedef enum logic [1:0] {
      MADD = 2'b00,
      MSUB = 2'b01,
      MMUL = 2'b10
   } op_e;

   localparam logic [1:0] OP_ILLEGAL = 2'b11;

   typedef enum logic [1:0] {
      LOAD_A = 2'b00,
      LOAD_B = 2'b01,
      EXEC   = 2'b10,
      DRAIN  = 2'b11
   } state_e;

   localparam int BEATS_PER_MAT = 3;
   localparam int ELEM_W        = 8;

endpackage

`default_nettype wire

// File: rtl/mac.sv
// ============================================================================
// mac : combinational 3x3 matrix add / subtract / multiply, modulo 2^VAR_WIDTH
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = 72,
   parameter int MAT_SIZE   = 3,
   parameter int VAR_WIDTH  = 8
) (
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [1:0]            op_i,
   output logic [DATA_WIDTH-1:0] result_o
);

   logic [VAR_WIDTH-1:0] a_m [MAT_SIZE][MAT_SIZE];
   logic [VAR_WIDTH-1:0] b_m [MAT_SIZE][MAT_SIZE];

   // Element [r][c] sits at the MSB end for r = c = 0 (row-major, big-endian).
   for (genvar r = 0; r < MAT_SIZE; r++) begin : g_row
      for (genvar c = 0; c < MAT_SIZE; c++) begin : g_col
         localparam int HI = DATA_WIDTH - 1 - (r * MAT_SIZE + c) * VAR_WIDTH;

         logic [VAR_WIDTH-1:0] dot;
         logic [VAR_WIDTH-1:0] res_e;

         assign a_m[r][c] = a_i[HI -: VAR_WIDTH];
         assign b_m[r][c] = b_i[HI -: VAR_WIDTH];

         always_comb begin
            dot = '0;
            for (int k = 0; k < MAT_SIZE; k++) begin
               dot = dot + a_m[r][k] * b_m[k][c];
            end
         end

         always_comb begin
            res_e = '0;
            case (op_i)
               MADD:    res_e = a_m[r][c] + b_m[r][c];
               MSUB:    res_e = a_m[r][c] - b_m[r][c];
               MMUL:    res_e = dot;
               default: res_e = '0;
            endcase
         end

         assign result_o[HI -: VAR_WIDTH] = res_e;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mac_seq.sv
// ============================================================================
// mac_seq : 32-bit stream sequencer around mac (load A, load B, exec, drain).
// Optional macro MAC_SEQ_PERF_EN adds the ops_done_o completed-op counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mac_seq
   import mac_pkg::*;
#(
   parameter int DATA_WIDTH = 72,
   parameter int MAT_SIZE   = 3,
   parameter int VAR_WIDTH  = 8,
   parameter int BUS_WIDTH  = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [BUS_WIDTH-1:0] in_data_i,
   input  logic [1:0]           op_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [BUS_WIDTH-1:0] out_data_o,
   output logic                 out_last_o,
   output logic                 busy_o,
   output logic                 err_o
`ifdef MAC_SEQ_PERF_EN
   ,
   output logic [15:0]          ops_done_o
`endif
);

   localparam logic [1:0] LAST_BEAT = 2'(BEATS_PER_MAT - 1);

   state_e                state;
   logic [1:0]            beat_cnt;
   logic [DATA_WIDTH-1:0] a_q;
   logic [DATA_WIDTH-1:0] b_q;
   logic [1:0]            op_q;
   logic [DATA_WIDTH-1:0] res_q;
   logic [DATA_WIDTH-1:0] mac_res;
   logic                  in_fire;
   logic                  out_fire;

   // Beats 0/1 fill whole bus words from the MSB end; beat 2 carries one element.
   function automatic logic [DATA_WIDTH-1:0] load_beat(
      input logic [DATA_WIDTH-1:0] cur,
      input logic [1:0]            idx,
      input logic [BUS_WIDTH-1:0]  data
   );
      logic [DATA_WIDTH-1:0] r;
      r = cur;
      case (idx)
         2'd0:    r[DATA_WIDTH-1 -: BUS_WIDTH]           = data;
         2'd1:    r[DATA_WIDTH-BUS_WIDTH-1 -: BUS_WIDTH] = data;
         default: r[VAR_WIDTH-1:0]                       = data[VAR_WIDTH-1:0];
      endcase
      return r;
   endfunction

   mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAT_SIZE   (MAT_SIZE),
      .VAR_WIDTH  (VAR_WIDTH)
   ) u_mac (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (mac_res)
   );

   assign in_fire  = in_valid_i && in_ready_o;
   assign out_fire = out_valid_o && out_ready_i;
   assign busy_o   = (state != LOAD_A) || (beat_cnt != 2'd0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= LOAD_A;
         beat_cnt    <= '0;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         res_q       <= '0;
         in_ready_o  <= 1'b1;
         out_valid_o <= 1'b0;
         out_data_o  <= '0;
         out_last_o  <= 1'b0;
         err_o       <= 1'b0;
      end else begin
         case (state)
            LOAD_A, LOAD_B: begin
               if (in_fire) begin
                  if (state == LOAD_A) begin
                     a_q <= load_beat(a_q, beat_cnt, in_data_i);
                     if (beat_cnt == 2'd0) begin
                        op_q <= op_i;
                        if (op_i == OP_ILLEGAL) err_o <= 1'b1;
                     end
                  end else begin
                     b_q <= load_beat(b_q, beat_cnt, in_data_i);
                  end
                  if (beat_cnt == LAST_BEAT) begin
                     beat_cnt <= '0;
                     if (state == LOAD_A) begin
                        state <= LOAD_B;
                     end else begin
                        state      <= EXEC;
                        in_ready_o <= 1'b0;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 2'd1;
                  end
               end
            end
            EXEC: begin
               res_q       <= mac_res;
               out_data_o  <= mac_res[DATA_WIDTH-1 -: BUS_WIDTH];
               out_valid_o <= 1'b1;
               state       <= DRAIN;
            end
            DRAIN: begin
               if (out_fire) begin
                  case (beat_cnt)
                     2'd0: begin
                        out_data_o <= res_q[DATA_WIDTH-BUS_WIDTH-1 -: BUS_WIDTH];
                        beat_cnt   <= 2'd1;
                     end
                     2'd1: begin
                        out_data_o <= {res_q[VAR_WIDTH-1:0], {(BUS_WIDTH-VAR_WIDTH){1'b0}}};
                        out_last_o <= 1'b1;
                        beat_cnt   <= 2'd2;
                     end
                     default: begin
                        out_data_o  <= '0;
                        out_last_o  <= 1'b0;
                        out_valid_o <= 1'b0;
                        in_ready_o  <= 1'b1;
                        beat_cnt    <= '0;
                        state       <= LOAD_A;
                     end
                  endcase
               end
            end
            default: state <= LOAD_A;
         endcase
      end
   end

`ifdef MAC_SEQ_PERF_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ops_done_o <= '0;
      end else if (state == DRAIN && out_fire && beat_cnt == 2'd2) begin
         ops_done_o <= ops_done_o + 16'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mac_seq.sv
// ============================================================================
// tb_mac_seq : table vectors, corner sequences and randomized ops vs a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mac_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [1:0]  op_in = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        err;
`ifdef MAC_SEQ_PERF_EN
   logic [15:0] ops_done;
`endif

   int vectors = 0;
   int miscompares = 0;
   logic err_exp = 1'b0;
   int   ops_exp = 0;

   always #5 clk = ~clk;

   mac_seq dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .in_data_i   (in_data),
      .op_i        (op_in),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_data_o  (out_data),
      .out_last_o  (out_last),
      .busy_o      (busy),
      .err_o       (err)
`ifdef MAC_SEQ_PERF_EN
      ,
      .ops_done_o  (ops_done)
`endif
   );

   typedef struct {
      logic [1:0]  op;
      logic [71:0] a;
      logic [71:0] b;
      logic [71:0] res;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: matrices as integer arrays, plain arithmetic, reduced mod 256.
   function automatic logic [71:0] model(input logic [1:0] op, input logic [71:0] a,
                                         input logic [71:0] b);
      int am [3][3];
      int bm [3][3];
      int v;
      logic [71:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            am[i][j] = int'(a[71 - 8*(3*i+j) -: 8]);
            bm[i][j] = int'(b[71 - 8*(3*i+j) -: 8]);
         end
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            case (op)
               2'd0: v = am[i][j] + bm[i][j];
               2'd1: v = am[i][j] - bm[i][j];
               2'd2: begin
                  v = 0;
                  for (int k = 0; k < 3; k++) v += am[i][k] * bm[k][j];
               end
               default: v = 0;
            endcase
            v = ((v % 256) + 256) % 256;
            r[71 - 8*(3*i+j) -: 8] = 8'(v);
         end
      return r;
   endfunction

   task automatic send_beat(input logic [31:0] d, input logic [1:0] op);
      int guard;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      op_in    = op;
      guard    = 0;
      while (!in_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) begin
         vectors++;
         miscompares++;
         $display("FAIL in_ready_timeout: got 0 expected 1 at %0t", $time);
      end
      @(posedge clk);
   endtask

   task automatic send_operands(input logic [1:0] op, input logic [71:0] a,
                                input logic [71:0] b, input int nbeats);
      logic [31:0] beats [6];
      beats[0] = a[71:40];
      beats[1] = a[39:8];
      beats[2] = {24'($urandom), a[7:0]};
      beats[3] = b[71:40];
      beats[4] = b[39:8];
      beats[5] = {24'($urandom), b[7:0]};
      for (int i = 0; i < nbeats; i++)
         send_beat(beats[i], (i == 0) ? op : 2'($urandom_range(0, 3)));
   endtask

   task automatic do_op(input logic [1:0] op, input logic [71:0] a, input logic [71:0] b,
                        input logic [71:0] res, input int stall0, input int stall_rest);
      logic [31:0] exp_beats [3];
      logic [31:0] hold;
      int lat;
      int s;
      exp_beats[0] = res[71:40];
      exp_beats[1] = res[39:8];
      exp_beats[2] = {res[7:0], 24'h0};
      send_operands(op, a, b, 6);
      lat = 0;
      do begin
         @(negedge clk);
         if (lat == 0) in_valid = 1'b0;
         lat++;
      end while (!out_valid && lat < 10);
      check("out_valid_latency", 32'(lat), 32'd2);
      check("in_ready_in_drain", 32'(in_ready), 32'd0);
      if (op == 2'b11) err_exp = 1'b1;
      check("err_flag", 32'(err), 32'(err_exp));
      for (int i = 0; i < 3; i++) begin
         s = (i == 0) ? stall0 : $urandom_range(0, stall_rest);
         hold = out_data;
         out_ready = 1'b0;
         for (int j = 0; j < s; j++) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, hold);
            check("stall_in_ready", 32'(in_ready), 32'd0);
         end
         out_ready = 1'b1;
         check("beat_valid", 32'(out_valid), 32'd1);
         check($sformatf("beat%0d_data", i), out_data, exp_beats[i]);
         check($sformatf("beat%0d_last", i), 32'(out_last), (i == 2) ? 32'd1 : 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b0;
      ops_exp++;
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
`ifdef MAC_SEQ_PERF_EN
      check("ops_done", 32'(ops_done), 32'(ops_exp & 16'hFFFF));
`endif
   endtask

   task automatic check_reset_state();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
`ifdef MAC_SEQ_PERF_EN
      check("rst_ops_done", 32'(ops_done), 32'd0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl [4];
      logic [71:0] ra;
      logic [71:0] rb;
      logic [1:0]  rop;

      tbl[0] = '{op: 2'b10, a: 72'h01_00_00_00_01_00_00_00_01,
                 b: 72'h01_02_03_04_05_06_07_08_09, res: 72'h01_02_03_04_05_06_07_08_09};
      tbl[1] = '{op: 2'b00, a: {9{8'h80}}, b: {9{8'h80}}, res: 72'h0};
      tbl[2] = '{op: 2'b01, a: 72'h0, b: {9{8'h01}}, res: {9{8'hFF}}};
      tbl[3] = '{op: 2'b10, a: {9{8'h02}}, b: {9{8'h02}}, res: {9{8'h0C}}};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state();

      for (int i = 0; i < 4; i++)
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, 0, 0);

      // Consumer stalls for 5 cycles on the first result beat.
      do_op(2'b10, tbl[0].a, tbl[0].b, tbl[0].res, 5, 0);

      // Illegal opcode: zero result, sticky error across a following legal op.
      do_op(2'b11, {9{8'h11}}, {9{8'h22}}, 72'h0, 0, 1);
      do_op(2'b00, {9{8'h11}}, {9{8'h22}}, {9{8'h33}}, 0, 1);

      // Abort after four input beats, then a fresh MADD.
      send_operands(2'b00, {9{8'h05}}, {9{8'h07}}, 4);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      err_exp = 1'b0;
      ops_exp = 0;
      check_reset_state();
      do_op(2'b00, 72'h01_02_03_04_05_06_07_08_09, {9{8'h10}},
            72'h11_12_13_14_15_16_17_18_19, 0, 0);

      for (int n = 0; n < 24; n++) begin
         ra  = {8'($urandom), 32'($urandom), 32'($urandom)};
         rb  = {8'($urandom), 32'($urandom), 32'($urandom)};
         rop = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         do_op(rop, ra, rb, model(rop, ra, rb), $urandom_range(0, 3), 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
